// File: rtl/add_seq_ctrl_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
// State encoding and index-width helper.
package add_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int words);
    return (words > 2) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_adder.sv
// Ripple-carry adder built from 1-bit full adders.
// Shared chunk datapath for the sequencer.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module FA_nbit_Using_1bit_FA #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;

  assign c[0] = cin;
  assign cout = c[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    fa_1bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end
endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit adder
// shared across WORDS chunks, LS chunk first, carry registered.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout
);
  localparam int TW = WIDTH * WORDS;
  localparam int IW = idx_width(WORDS);

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [TW-1:0]    opa;
  logic [TW-1:0]    opb;
  logic [TW-1:0]    acc;
  logic [TW-1:0]    acc_nxt;
  logic [WIDTH-1:0] ca;
  logic [WIDTH-1:0] cb;
  logic [WIDTH-1:0] cs;
  logic             co;
  logic             last;

  assign ca   = opa[idx*WIDTH +: WIDTH];
  assign cb   = opb[idx*WIDTH +: WIDTH];
  assign last = (idx == IW'(WORDS - 1));

  FA_nbit_Using_1bit_FA #(.N(WIDTH)) u_add (
    .a   (ca),
    .b   (cb),
    .cin (carry),
    .sum (cs),
    .cout(co)
  );

  // Accumulator with the current chunk merged in, so the last
  // chunk lands in sum on the same edge it is computed.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[idx*WIDTH +: WIDTH] = cs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= co;
          if (last) begin
            sum   <= acc_nxt;
            cout  <= co;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (WIDTH=8, WORDS=4).
// Directed vectors, expected results pushed at issue, popped on done.
module tb_add_seq_ctrl;
  localparam int W = 8;
  localparam int N = 4;
  localparam int T = W * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [T-1:0] a = '0;
  logic [T-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [T-1:0] sum;
  logic         cout;

  add_seq_ctrl #(.WIDTH(W), .WORDS(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .cin  (cin),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [T-1:0] s;
    logic         c;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs = 0;
  int   dones = 0;
  logic done_d = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      if (done_d) begin
        vectors++;
        errs++;
        $display("FAIL done_width: done high two cycles");
      end
      if (q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_done: sum %h with empty queue", sum);
      end else begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
      end
    end
    done_d <= done;
  end

  task automatic go(input logic [T-1:0] ta, input logic [T-1:0] tb_,
                    input logic ci, input logic su,
                    input logic [T-1:0] es, input logic ec);
    @(negedge clk);
    a = ta;
    b = tb_;
    cin = ci;
    sub = su;
    start = 1'b1;
    q.push_back('{s: es, c: ec});
  endtask

  task automatic wait_done(input bit hold, output int nb);
    int t = 0;
    nb = 0;
    while (!done && t < 20) begin
      if (busy) nb++;
      if (hold) begin
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      @(negedge clk);
      t++;
    end
    if (!done) begin
      vectors++;
      errs++;
      $display("FAIL timeout: no done after %0d cycles", t);
    end
  endtask

  initial begin
    int nb;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", 64'({busy, done, cout, sum}), 64'd0);
    end

    // carry across chunk boundary
    go(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);
    chk("busy_cycles", 64'(nb), 64'd4);

    // full chain then back-to-back at earliest accept
    go(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    q.push_back('{s: 32'h2345_6789, c: 1'b0});
    @(negedge clk);
    chk("no_accept_in_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("accept_at_6", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(1'b0, nb);
    chk("busy_cycles_b2b", 64'(nb), 64'd4);

    // subtract, borrow and no borrow
    go(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);
    go(32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);

    // start held, inputs churned during RUN
    go(32'hF0F0_F0F0, 32'h1010_1010, 1'b0, 1'b0, 32'h0101_0100, 1'b1);
    @(negedge clk);
    wait_done(1'b1, nb);
    chk("busy_cycles_hold", 64'(nb), 64'd4);
    start = 1'b0;
    sub = 1'b0;
    cin = 1'b0;

    // reset mid-op: no result pushed, so a done would be flagged
    @(negedge clk);
    @(negedge clk);
    a = 32'h0000_0001;
    b = 32'h0000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'({busy, done}), 64'd0);
    go(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("done_count", 64'(dones), 64'd7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It time-shares one WIDTH-bit ripple-carry adder across WORDS chunks to add two WORDS*WIDTH-bit operands. One chunk is processed per clock, least-significant chunk first. The carry is registered between chunks. This is the control layer above the team's n-bit adder datapath and serves blocks that need wide arithmetic without a full-width ripple chain.

Parameters:
WIDTH, 8, bit width of the shared adder and of one chunk.
WORDS, 4, number of chunks per operand (>=2). Total operand width is WIDTH*WORDS.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request. Sampled only in IDLE.
sub  input  1  0 = a+b+cin. 1 = a-b (b inverted, initial carry forced to 1, cin ignored).
cin  input  1  carry-in for the add operation.
a  input  WIDTH*WORDS  operand A. Captured on the start-accept edge.
b  input  WIDTH*WORDS  operand B. Captured on the start-accept edge.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
sum  output  WIDTH*WORDS  registered result. Holds until the next completion.
cout  output  1  final carry-out. For sub=1, 1 means no borrow (a>=b unsigned).

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal chunk index, carry and captured operands are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge, latch a and (sub ? ~b : b) into operand registers.
  - Latch carry register = sub ? 1 : cin, set idx=0, go to RUN.
  - If start=0, stay in IDLE.
- RUN, at each edge:
  - Adder inputs = chunk idx of A and B plus the carry register.
  - The adder WIDTH-bit sum is written into accumulator chunk idx.
  - Carry register <= adder carry-out; idx <= idx+1.
  - When idx==WORDS-1, on that edge copy the full accumulator (with the last chunk) to sum, copy the adder carry-out to cout, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. start is ignored in DONE.
- Latency:
  - Start-accept edge E0; result edges E1..E_WORDS.
  - sum/cout update and done rises after edge E_WORDS, i.e. WORDS cycles after acceptance.
  - Next start is accepted no earlier than edge E_WORDS+2. Throughput is one op per WORDS+2 cycles.
- start while busy or in DONE is ignored and not queued. The operand registers and the a/b/cin/sub inputs have no effect after E0.
- The sum output never shows partial results. Only the internal accumulator changes mid-operation.
- Arithmetic is modulo 2^(WIDTH*WORDS). cout is the carry out of the top chunk. No overflow flag.
- idx width is clog2(WORDS) with a minimum of 1 bit. idx never wraps past WORDS-1 because the state leaves RUN.
- Reset asserted mid-RUN aborts immediately. sum/cout go to 0, with no done pulse. After release, the block is in IDLE.
- Unused/illegal state encodings recover to IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE) and the clog2-based index-width function.
- Sub-module: one instance of the team's existing ripple-carry adder FA_nbit_Using_1bit_FA #(WIDTH) as the shared datapath.
- All sequencing, chunk muxing and accumulator write-back stay in add_seq_ctrl.

Test Plan (WIDTH=8, WORDS=4):
- Reset then idle: rst pulse, start=0 for 10 cycles -> busy=0, done=0, sum=0x00000000, cout=0 throughout.
- Carry ripple across a chunk boundary: a=0x000000FF, b=0x00000001, cin=0, sub=0, start one cycle -> busy for 4 cycles, done pulse 4 cycles after accept, sum=0x00000100, cout=0.
- Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Then a=0x12345678, b=0x11111111, cin=0 back-to-back at the earliest accept -> sum=0x23456789, cout=0, accepted exactly 6 cycles after the first.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
- Ignored start:
  - Hold start=1 and change a/b every cycle during RUN -> result reflects only the E0 operands.
  - Exactly one done pulse per accepted op.
  - After done, start=1 is accepted only from IDLE.
- Reset mid-op: assert rst after 2 RUN cycles, asynchronously between edges -> busy/sum/cout drop to 0 immediately, no done. A new op after release completes correctly.
